// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file constants and word/index types
package cpu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_SP = 29;
  localparam int SP_RESET = 128;
  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_read_port.sv
// reg_read_port: combinational register read with zero-register and write-forward rules
module reg_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  regs,
  input  logic                                fwd_en,
  input  logic [ADDR_W-1:0]                   fwd_addr,
  input  logic [DATA_W-1:0]                   fwd_data,
  output logic [DATA_W-1:0]                   data
);
  always_comb
    data = (addr == ADDR_W'(REG_ZERO)) ? '0 :
           (fwd_en && fwd_addr == addr) ? fwd_data : regs[addr];
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: 32-entry register file with bypassed read ports, debug port and write counter
module reg_file_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SP_IDX  = REG_SP,
  parameter int SP_INIT = SP_RESET,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic [15:0]       wr_count_o
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic commit;
  logic fwd_en;
  always_comb begin
    commit = reg_write_i && rd_addr_i != ADDR_W'(REG_ZERO);
    fwd_en = BYPASS && rst_i && commit;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      wr_count_o <= '0;
    end else if (commit) begin
      regs[rd_addr_i] <= rd_data_i;
      wr_count_o <= wr_count_o + 16'd1;
    end
  end
  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs (
    .addr(rs_addr_i), .regs(regs), .fwd_en(fwd_en), .fwd_addr(rd_addr_i),
    .fwd_data(rd_data_i), .data(rs_data_o)
  );
  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt (
    .addr(rt_addr_i), .regs(regs), .fwd_en(fwd_en), .fwd_addr(rd_addr_i),
    .fwd_data(rd_data_i), .data(rt_data_o)
  );
  // debug view always shows committed state
  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
    .addr(dbg_addr_i), .regs(regs), .fwd_en(1'b0), .fwd_addr('0),
    .fwd_data('0), .data(dbg_data_o)
  );
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: randomized self-checking bench for reg_file_wb against an array model
module tb_reg_file_wb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] rs_addr = '0, rt_addr = '0, rd_addr = '0, dbg_addr = '0;
  logic [31:0] rd_data = '0;
  logic we = 1'b0;
  logic [31:0] rs_a, rt_a, dbg_a, rs_b, rt_b, dbg_b;
  logic [15:0] cnt_a, cnt_b;
  logic [31:0] m [32];
  logic [15:0] cnt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  reg_file_wb #(.BYPASS(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rd_addr_i(rd_addr), .rd_data_i(rd_data), .reg_write_i(we), .dbg_addr_i(dbg_addr),
    .rs_data_o(rs_a), .rt_data_o(rt_a), .dbg_data_o(dbg_a), .wr_count_o(cnt_a)
  );
  reg_file_wb #(.BYPASS(1'b0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .rd_addr_i(rd_addr), .rd_data_i(rd_data), .reg_write_i(we), .dbg_addr_i(dbg_addr),
    .rs_data_o(rs_b), .rt_data_o(rt_b), .dbg_data_o(dbg_b), .wr_count_o(cnt_b)
  );
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && we && rst && rd_addr == a) return rd_data;
    return m[a];
  endfunction
  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      foreach (m[i]) m[i] = (i == 29) ? 32'd128 : 32'd0;
      cnt = 16'd0;
    end else if (we && rd_addr != 5'd0) begin
      m[rd_addr] = rd_data;
      cnt = cnt + 16'd1;
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b0; we = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      #1;
      total++;
      if (rs_a !== ((i == 29) ? 32'd128 : 32'd0)) begin
        bad++; $display("FAIL reset_rs[%0d] got=%h want=%h", i, rs_a, (i == 29) ? 32'd128 : 32'd0);
      end
      total++;
      if (rs_b !== ((i == 29) ? 32'd128 : 32'd0)) begin
        bad++; $display("FAIL reset_rs_nb[%0d] got=%h", i, rs_b);
      end
    end
    total++;
    if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
      bad++; $display("FAIL reset_count got=%0d/%0d want=0", cnt_a, cnt_b);
    end
  endtask
  task automatic test_basic();
    we = 1'b1; rd_addr = 5'd8; rd_data = 32'hDEADBEEF;
    cycle();
    we = 1'b0; rs_addr = 5'd8; rt_addr = 5'd8;
    #1;
    total++;
    if (rs_a !== 32'hDEADBEEF || rt_a !== 32'hDEADBEEF) begin
      bad++; $display("FAIL basic_read got=%h/%h want=deadbeef", rs_a, rt_a);
    end
    total++;
    if (cnt_a !== 16'd1) begin
      bad++; $display("FAIL basic_count got=%0d want=1", cnt_a);
    end
  endtask
  task automatic test_r0();
    we = 1'b1; rd_addr = 5'd0; rd_data = 32'h12345678; rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    total++;
    if (rs_a !== 32'd0 || rt_a !== 32'd0) begin
      bad++; $display("FAIL r0_bypass got=%h/%h want=0", rs_a, rt_a);
    end
    cycle();
    we = 1'b0; dbg_addr = 5'd0;
    #1;
    total++;
    if (rs_a !== 32'd0 || dbg_a !== 32'd0) begin
      bad++; $display("FAIL r0_read got=%h/%h want=0", rs_a, dbg_a);
    end
    total++;
    if (cnt_a !== 16'd1) begin
      bad++; $display("FAIL r0_count got=%0d want=1", cnt_a);
    end
  endtask
  task automatic test_bypass();
    we = 1'b1; rd_addr = 5'd5; rd_data = 32'hA5A5A5A5; rs_addr = 5'd5; rt_addr = 5'd5; dbg_addr = 5'd5;
    #1;
    total++;
    if (rs_a !== 32'hA5A5A5A5 || rt_a !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL bypass_fwd got=%h/%h want=a5a5a5a5", rs_a, rt_a);
    end
    total++;
    if (dbg_a !== 32'd0) begin
      bad++; $display("FAIL bypass_dbg got=%h want=0", dbg_a);
    end
    total++;
    if (rs_b !== 32'd0 || rt_b !== 32'd0) begin
      bad++; $display("FAIL nobypass_old got=%h/%h want=0", rs_b, rt_b);
    end
    cycle();
    we = 1'b0;
    #1;
    total++;
    if (rs_b !== 32'hA5A5A5A5 || dbg_a !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL nobypass_new got=%h/%h want=a5a5a5a5", rs_b, dbg_a);
    end
  endtask
  task automatic test_collision();
    rst = 1'b0; we = 1'b1; rd_addr = 5'd29; rd_data = 32'hFFFFFFFF; rs_addr = 5'd29; rt_addr = 5'd8;
    #1;
    total++;
    if (rs_a !== 32'd128) begin
      bad++; $display("FAIL coll_no_fwd got=%h want=80", rs_a);
    end
    total++;
    if (rt_a !== 32'hDEADBEEF) begin
      bad++; $display("FAIL coll_prereset got=%h want=deadbeef", rt_a);
    end
    cycle();
    rst = 1'b1; we = 1'b0;
    #1;
    total++;
    if (rs_a !== 32'd128 || rt_a !== 32'd0) begin
      bad++; $display("FAIL coll_after got=%h/%h want=80/0", rs_a, rt_a);
    end
    total++;
    if (cnt_a !== 16'd0) begin
      bad++; $display("FAIL coll_count got=%0d want=0", cnt_a);
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      we = 1'($urandom);
      rd_addr = 5'($urandom);
      rd_data = $urandom;
      rs_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom);
      rt_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom);
      dbg_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom);
      #1;
      total++;
      if (rs_a !== exp_rd(rs_addr, 1) || rt_a !== exp_rd(rt_addr, 1)) begin
        bad++; $display("FAIL rand_byp n=%0d got=%h/%h want=%h/%h", n, rs_a, rt_a, exp_rd(rs_addr, 1), exp_rd(rt_addr, 1));
      end
      total++;
      if (rs_b !== exp_rd(rs_addr, 0) || rt_b !== exp_rd(rt_addr, 0)) begin
        bad++; $display("FAIL rand_nobyp n=%0d got=%h/%h want=%h/%h", n, rs_b, rt_b, exp_rd(rs_addr, 0), exp_rd(rt_addr, 0));
      end
      total++;
      if (dbg_a !== exp_rd(dbg_addr, 0) || dbg_b !== exp_rd(dbg_addr, 0)) begin
        bad++; $display("FAIL rand_dbg n=%0d got=%h/%h want=%h", n, dbg_a, dbg_b, exp_rd(dbg_addr, 0));
      end
      total++;
      if (cnt_a !== cnt || cnt_b !== cnt) begin
        bad++; $display("FAIL rand_count n=%0d got=%0d/%0d want=%0d", n, cnt_a, cnt_b, cnt);
      end
      cycle();
    end
    rst = 1'b1; we = 1'b0;
  endtask
  task automatic test_wrap();
    rst = 1'b0; we = 1'b0;
    cycle();
    rst = 1'b1; we = 1'b1; rd_addr = 5'd1;
    for (int n = 0; n < 65537; n++) begin
      rd_data = $urandom;
      cycle();
    end
    we = 1'b0; rs_addr = 5'd1; dbg_addr = 5'd1;
    #1;
    total++;
    if (cnt_a !== 16'd1 || cnt !== 16'd1) begin
      bad++; $display("FAIL wrap_count got=%0d want=1", cnt_a);
    end
    total++;
    if (rs_a !== rd_data || dbg_a !== rd_data) begin
      bad++; $display("FAIL wrap_data got=%h/%h want=%h", rs_a, dbg_a, rd_data);
    end
  endtask
  initial begin
    foreach (m[i]) m[i] = 32'd0;
    cnt = 16'd0;
    test_reset();
    test_basic();
    test_r0();
    test_bypass();
    test_collision();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32-entry general-purpose register file for the single-cycle CPU.
- Sits directly downstream of the write-back data select: the 2:1 result mux (ALU result vs. memory data) drives rd_data_i; the destination-register select mux drives rd_addr_i.
- Two combinational read ports feed the ALU operand path. One synchronous write port commits results at the clock edge.
- Optional write-to-read bypass and a debug read port for the testbench.

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- SP_IDX, 29, index of the stack-pointer register.
- SP_INIT, 128, reset value of the stack-pointer register.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- rs_addr_i  in  ADDR_W  read port A index.
- rt_addr_i  in  ADDR_W  read port B index.
- rd_addr_i  in  ADDR_W  write index, from the destination select mux.
- rd_data_i  in  DATA_W  write data, from the write-back result mux.
- reg_write_i  in  1  write enable from the control unit.
- dbg_addr_i  in  ADDR_W  debug read index.
- rs_data_o  out  DATA_W  read port A data.
- rt_data_o  out  DATA_W  read port B data.
- dbg_data_o  out  DATA_W  debug read data; never bypassed.
- wr_count_o  out  16  number of committed writes since reset.

Behaviour:
- Storage: array regs[0 .. 2**ADDR_W-1], each DATA_W bits.
- Reset, applied at a rising clk_i with rst_i==0:
  - all regs become 0, except regs[SP_IDX], which becomes SP_INIT;
  - wr_count_o becomes 0.
  - Reset wins over a simultaneous write; no write commits in that cycle.
- Write: at a rising clk_i with rst_i==1, reg_write_i==1 and rd_addr_i!=0:
  - regs[rd_addr_i] <= rd_data_i;
  - wr_count_o increments by 1 and wraps from 0xFFFF to 0.
- Writes to index 0 are discarded and do not increment wr_count_o.
- reg_write_i==0 means no state change.
- Register 0: reads always return 0, regardless of stored contents or bypass.
- Reads: combinational, zero latency.
  - rs_data_o = regs[rs_addr_i], rt_data_o = regs[rt_addr_i].
- Bypass (BYPASS==1):
  - If reg_write_i==1, rst_i==1, rd_addr_i!=0 and rd_addr_i==rs_addr_i, then rs_data_o = rd_data_i in the same cycle. Same rule for rt_data_o.
  - Both ports may bypass at once when rs_addr_i==rt_addr_i==rd_addr_i.
  - No bypass while rst_i==0.
- With BYPASS==0: reads return the pre-edge value; the new value is visible the cycle after the write.
- dbg_data_o = regs[dbg_addr_i]; index 0 reads 0; never bypassed.
- Output values after reset: read ports return 0 for any index except SP_IDX, which returns SP_INIT; wr_count_o is 0.
- No X propagation: every reg is initialised by reset. Reads before the first reset are undefined and not checked.
- Reset asserted mid-program clears state at the next edge. Reads in the same cycle still show the pre-reset contents, because reset is synchronous.

Decomposition:
- Shared package (cpu_pkg):
  - REG_ZERO = 0, REG_SP = 29, SP_RESET = 128;
  - DATA_W / ADDR_W defaults;
  - typedef reg_idx_t (ADDR_W bits) and word_t (DATA_W bits).
- One natural sub-module: reg_read_port.
  - Combinational: index, array view, write-forward signals -> data.
  - Applies the zero-register and bypass rules.
  - Instantiated three times: rs, rt, and debug with bypass tied off.
- Write logic and wr_count_o stay in the top module.

Test Plan:
- Reset: hold rst_i=0 for 2 edges, then release; sweep rs_addr_i 0..31 -> rs_data_o = 0 for all indices except 29, which reads 128; wr_count_o = 0.
- Basic write/read: write 0xDEADBEEF to r8, then read rs=8 and rt=8 on the next cycle -> both read 0xDEADBEEF; wr_count_o = 1.
- r0 protection: write 0x12345678 to r0 -> rs_data_o(0) = 0 and dbg_data_o(0) = 0; wr_count_o unchanged.
- Bypass: with BYPASS=1, in the same cycle set reg_write_i=1, rd_addr_i=5, rd_data_i=0xA5A5A5A5, rs_addr_i=rt_addr_i=5 -> both outputs read 0xA5A5A5A5 before the edge; dbg_addr_i=5 still reads the old value. With BYPASS=0 -> outputs show the old value until after the edge.
- Reset vs. write collision: rst_i=0 together with a write of 0xFFFFFFFF to r29 -> after the edge r29 = 128 and wr_count_o = 0.
- Counter wrap: perform 65537 writes to r1 -> wr_count_o = 1; r1 holds the last data written.
